regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Producer side of the CR16 register file write port: merges single-cycle ALU results and multi-cycle memory load returns into one registered write stream (wr_en/wr_addr/wr_data).
- Buffers load returns in a small FIFO with a valid/ready handshake.
- Keeps a busy scoreboard of registers with outstanding loads so issue logic can stall on hazards.

Parameters:
WIDTH, 16, data width of a register
REGISTER_BITS, 4, register address width (2^REGISTER_BITS registers)
FIFO_DEPTH, 4, load-return buffer entries; power of two, >= 2
STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose to the ALU before forced drain

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high; clears all state
alu_valid  input  1  ALU result present this cycle
alu_addr  input  REGISTER_BITS  ALU destination register
alu_data  input  WIDTH  ALU result
alu_stall  output  1  registered; ALU must hold its result this cycle, alu_valid ignored
mem_valid  input  1  load return valid
mem_ready  output  1  FIFO can accept a load return
mem_addr  input  REGISTER_BITS  load destination register
mem_data  input  WIDTH  load data
load_issue  input  1  a load is being issued this cycle
load_dest  input  REGISTER_BITS  destination of the issued load
busy_mask  output  2^REGISTER_BITS  bit n set = register n awaits a load
issue_conflict  output  1  registered pulse: load_issue targeted an already-busy register
wr_en  output  1  register file write enable
wr_addr  output  REGISTER_BITS  register file write address
wr_data  output  WIDTH  register file write data

Behaviour:
- Reset: wr_en=0, wr_addr=0, wr_data=0, alu_stall=0, issue_conflict=0, busy_mask=0, FIFO empty, starvation counter=0, mem_ready=1 on the following cycle. Reset mid-operation discards buffered loads without writing them.
- mem_ready = (count != FIFO_DEPTH), derived from registered count only. A push occurs when mem_valid && mem_ready. A full FIFO never accepts a push, even if a pop happens in the same cycle.
- Selection each cycle:
  - If alu_valid && !alu_stall: ALU wins.
  - Else if FIFO is non-empty: pop the head.
  - Else: no write.
- The selected write appears on wr_* on the next cycle. ALU latency is 1; minimum load latency is 2 (push, then pop, then output).
- Starvation: the counter increments each cycle the FIFO is non-empty and the ALU wins, and clears on any pop or when the FIFO is empty. When it reaches STARVE_LIMIT, alu_stall=1 for exactly the next cycle, the head pops that cycle, and the counter clears.
- Register 0: a selected write to address 0 still pops or clears state, but wr_en stays 0.
- Scoreboard:
  - load_issue with load_dest != 0 sets the busy bit on the next cycle.
  - A popped load clears busy[mem_addr of head] when selected.
  - Set and clear of the same bit in one cycle: set wins.
  - load_issue to a busy register: bit stays set, issue_conflict=1 for one cycle.
  - load_issue to address 0: ignored.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is 0..FIFO_DEPTH inclusive.

Optional Feature:
REGFILE_WRITE_BYPASS_EN
- Defined: adds inputs byp_addr1 and byp_addr2 (REGISTER_BITS each) and outputs byp_hit1/byp_hit2 (1) and byp_data1/byp_data2 (WIDTH). They are combinational from the current wr_* outputs. hitN = wr_en && (wr_addr == byp_addrN) && (byp_addrN != 0); byp_dataN = wr_data.
- Undefined: these ports and their logic are absent. Readers see new data one cycle after the write.

Decomposition:
- Shared package cr16_regfile_pkg holds:
  - WIDTH/REGISTER_BITS defaults
  - reg_addr_t and reg_data_t typedefs
  - the ZERO_REG constant
  - a wb_entry_t struct {addr, data}
- One sub-module, regfile_wb_fifo: a synchronous FIFO of wb_entry_t with push/pop/full/empty/count. Arbitration, starvation and scoreboard stay in the top.

Test Plan:
- ALU only: alu_valid with addr=3, data=0x1234 -> next cycle wr_en=1, wr_addr=3, wr_data=0x1234, mem_ready stays 1.
- Load path: load_issue dest=5 -> busy_mask bit5=1. Later, mem_valid addr=5, data=0xBEEF with no ALU -> write appears 2 cycles after the push, and bit5 clears in the same cycle as the output.
- Full FIFO: push 4 loads while alu_valid is held high -> mem_ready=0 after the 4th push. A 5th mem_valid is not accepted until a pop occurs.
- Starvation: FIFO holds 1 entry and alu_valid stays high -> after 4 lost cycles alu_stall=1 for one cycle and the load is written, then ALU writes resume.
- Hazards:
  - load_issue dest=5 twice -> issue_conflict pulses once.
  - load_issue dest=0 -> busy_mask unchanged.
  - ALU write to addr 0 -> wr_en stays 0.
- Reset mid-run with 3 buffered loads -> next cycle wr_en=0, busy_mask=0, mem_ready=1, and none of the buffered data is ever written.

Source files
------------

// File: rtl/cr16_regfile_pkg.sv
// Shared types for the CR16 register-file write path.
// The register width and address width live here. Every block that carries
// a register address or a register value picks these types up from this package.
package cr16_regfile_pkg;

  localparam int WIDTH         = 16;
  localparam int REGISTER_BITS = 4;
  localparam int NUM_REGS      = 1 << REGISTER_BITS;

  typedef logic [REGISTER_BITS-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0]         reg_data_t;
  typedef logic [NUM_REGS-1:0]      reg_mask_t;

  // Register 0 is hard-wired. Writes to it are dropped, and it is never busy.
  localparam reg_addr_t ZERO_REG = '0;

  // One pending register-file write.
  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the execution units and the register-file write arbiter.
// master: the producer side (ALU, load unit, issue logic).
// slave:  the arbiter.
// Optional macro: REGFILE_WRITE_BYPASS_EN adds the two forwarding read ports.
interface regfile_write_arbiter_if;
  import cr16_regfile_pkg::*;

  logic      alu_valid;
  reg_addr_t alu_addr;
  reg_data_t alu_data;
  logic      alu_stall;

  logic      mem_valid;
  logic      mem_ready;
  reg_addr_t mem_addr;
  reg_data_t mem_data;

  logic      load_issue;
  reg_addr_t load_dest;
  reg_mask_t busy_mask;
  logic      issue_conflict;

  logic      wr_en;
  reg_addr_t wr_addr;
  reg_data_t wr_data;

`ifdef REGFILE_WRITE_BYPASS_EN
  reg_addr_t byp_addr1, byp_addr2;
  logic      byp_hit1, byp_hit2;
  reg_data_t byp_data1, byp_data2;
`endif

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           load_issue, load_dest,
`ifdef REGFILE_WRITE_BYPASS_EN
    output byp_addr1, byp_addr2,
    input  byp_hit1, byp_hit2, byp_data1, byp_data2,
`endif
    input  alu_stall, mem_ready, busy_mask, issue_conflict,
           wr_en, wr_addr, wr_data
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           load_issue, load_dest,
`ifdef REGFILE_WRITE_BYPASS_EN
    input  byp_addr1, byp_addr2,
    output byp_hit1, byp_hit2, byp_data1, byp_data2,
`endif
    output alu_stall, mem_ready, busy_mask, issue_conflict,
           wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/regfile_wb_fifo.sv
// Synchronous FIFO of pending load-return writes.
// A push into a full FIFO is dropped, and a pop from an empty FIFO is ignored.
// A full FIFO refuses a push even when a pop happens in the same cycle.
module regfile_wb_fifo
  import cr16_regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Occupancy next-state.
  always_comb begin
    // NOTE: assign a default before any branch so the combinational block can never infer a latch.
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Entry storage.
  always_ff @(posedge clock) begin
    // NOTE: the storage array has no reset. The count and pointers decide which entries are valid, so old contents are harmless.
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers and count. The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples its pre-edge value.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// CR16 register-file write arbiter.
// It merges single-cycle ALU results with buffered load returns into one
// registered write port. If loads wait too long behind the ALU, it forces a drain.
// It also keeps a busy scoreboard of registers that are waiting for a load.
// Data and address widths come from cr16_regfile_pkg.
// Optional macro: REGFILE_WRITE_BYPASS_EN adds combinational forwarding of the current write.
module regfile_write_arbiter
  import cr16_regfile_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic                    clock,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  wb_entry_t     push_entry, fifo_head;
  logic          fifo_full, fifo_empty;
  logic          push, pop, alu_win, issue_set;

  logic          alu_stall_q, alu_stall_d;
  logic [SW-1:0] starve_q, starve_d;
  reg_mask_t     busy_q, busy_d;
  logic          conflict_q, conflict_d;
  logic          wr_en_q, wr_en_d;
  reg_addr_t     wr_addr_q, wr_addr_d;
  reg_data_t     wr_data_q, wr_data_d;

  // While the ALU is stalled its request is ignored, which lets the FIFO head drain.
  assign alu_win   = bus.alu_valid && !alu_stall_q;
  assign pop       = !alu_win && !fifo_empty;
  assign push      = bus.mem_valid && !fifo_full;
  assign issue_set = bus.load_issue && (bus.load_dest != ZERO_REG);
  assign push_entry.addr = bus.mem_addr;
  assign push_entry.data = bus.mem_data;

  regfile_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Next-state logic for the write selection, the starvation guard and the scoreboard.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (alu_win) begin
      wr_en_d   = (bus.alu_addr != ZERO_REG);
      wr_addr_d = bus.alu_addr;
      wr_data_d = bus.alu_data;
    end else if (pop) begin
      wr_en_d   = (fifo_head.addr != ZERO_REG);
      wr_addr_d = fifo_head.addr;
      wr_data_d = fifo_head.data;
    end

    // The counter counts only the cycles in which a waiting load loses to the ALU.
    if (fifo_empty || pop) starve_d = '0;
    else if (alu_win)      starve_d = starve_q + 1'b1;
    else                   starve_d = starve_q;
    alu_stall_d = (starve_d == STARVE_MAX);

    // If a bit is set and cleared in the same cycle, the set wins, so it is applied last.
    busy_d = busy_q;
    if (pop)       busy_d[fifo_head.addr] = 1'b0;
    if (issue_set) busy_d[bus.load_dest]  = 1'b1;
    conflict_d = issue_set && busy_q[bus.load_dest];
  end

  // Registered outputs and arbitration state.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      alu_stall_q <= 1'b0;
      starve_q    <= '0;
      busy_q      <= '0;
      conflict_q  <= 1'b0;
    end else begin
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      alu_stall_q <= alu_stall_d;
      starve_q    <= starve_d;
      busy_q      <= busy_d;
      conflict_q  <= conflict_d;
    end
  end

  assign bus.alu_stall      = alu_stall_q;
  assign bus.mem_ready      = !fifo_full;
  assign bus.busy_mask      = busy_q;
  assign bus.issue_conflict = conflict_q;
  assign bus.wr_en          = wr_en_q;
  assign bus.wr_addr        = wr_addr_q;
  assign bus.wr_data        = wr_data_q;

`ifdef REGFILE_WRITE_BYPASS_EN
  // Forward the write that is on the port this cycle to the two readers.
  assign bus.byp_hit1  = wr_en_q && (wr_addr_q == bus.byp_addr1) && (bus.byp_addr1 != ZERO_REG);
  assign bus.byp_hit2  = wr_en_q && (wr_addr_q == bus.byp_addr2) && (bus.byp_addr2 != ZERO_REG);
  assign bus.byp_data1 = wr_data_q;
  assign bus.byp_data2 = wr_data_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
// Inputs change 1 time unit after each rising edge, and outputs are checked at that same point.
module tb_regfile_write_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid  = 1'b0;
    bus.alu_addr   = '0;
    bus.alu_data   = '0;
    bus.mem_valid  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_data   = '0;
    bus.load_issue = 1'b0;
    bus.load_dest  = '0;
  endtask

  task automatic alu(input logic v, input logic [3:0] a, input logic [15:0] d);
    bus.alu_valid = v;
    bus.alu_addr  = a;
    bus.alu_data  = d;
  endtask

  task automatic mem(input logic v, input logic [3:0] a, input logic [15:0] d);
    bus.mem_valid = v;
    bus.mem_addr  = a;
    bus.mem_data  = d;
  endtask

  task automatic issue(input logic v, input logic [3:0] a);
    bus.load_issue = v;
    bus.load_dest  = a;
  endtask

  initial begin
    idle();
`ifdef REGFILE_WRITE_BYPASS_EN
    bus.byp_addr1 = '0;
    bus.byp_addr2 = '0;
`endif
    // Reset state
    step();
    step();
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_stall", bus.alu_stall, 0);
    check("rst_conflict", bus.issue_conflict, 0);
    check("rst_busy", bus.busy_mask, 0);
    check("rst_mem_ready", bus.mem_ready, 1);
    reset = 1'b0;

    // ALU only: one-cycle latency
    alu(1, 4'd3, 16'h1234);
    step();
    alu(0, 0, 0);
    check("alu_wr_en", bus.wr_en, 1);
    check("alu_wr_addr", bus.wr_addr, 3);
    check("alu_wr_data", bus.wr_data, 16'h1234);
    check("alu_mem_ready", bus.mem_ready, 1);
    step();
    check("alu_idle_wr_en", bus.wr_en, 0);

    // Scoreboard set, double issue conflict, issue to r0 ignored
    issue(1, 4'd5);
    step();
    check("busy_set5", bus.busy_mask, 16'h0020);
    check("conflict_first", bus.issue_conflict, 0);
    step();
    check("conflict_pulse", bus.issue_conflict, 1);
    check("busy_still5", bus.busy_mask, 16'h0020);
    issue(1, 4'd0);
    step();
    issue(0, 0);
    check("conflict_once", bus.issue_conflict, 0);
    check("busy_r0_ignored", bus.busy_mask, 16'h0020);

    // Load path: the write appears two edges after the push, together with the busy clear
    mem(1, 4'd5, 16'hBEEF);
    step();
    mem(0, 0, 0);
    check("load_lat1_wr_en", bus.wr_en, 0);
    check("load_lat1_busy", bus.busy_mask, 16'h0020);
    step();
    check("load_wr_en", bus.wr_en, 1);
    check("load_wr_addr", bus.wr_addr, 5);
    check("load_wr_data", bus.wr_data, 16'hBEEF);
    check("load_busy_clr", bus.busy_mask, 16'h0000);

    // ALU write to r0 is suppressed
    alu(1, 4'd0, 16'h5555);
    step();
    alu(0, 0, 0);
    check("r0_wr_en", bus.wr_en, 0);

    // Set and clear of the same busy bit in one cycle: the set wins
    issue(1, 4'd5);
    mem(1, 4'd5, 16'h5A5A);
    step();
    issue(0, 0);
    mem(0, 0, 0);
    check("sc_busy_pre", bus.busy_mask, 16'h0020);
    issue(1, 4'd5);
    step();
    issue(0, 0);
    check("sc_wr_data", bus.wr_data, 16'h5A5A);
    check("sc_busy_set_wins", bus.busy_mask, 16'h0020);
    check("sc_conflict", bus.issue_conflict, 1);

    // Full FIFO while the ALU holds the port
    alu(1, 4'd1, 16'h1111);
    mem(1, 4'd6, 16'h6006);
    step();
    check("full_ready_e1", bus.mem_ready, 1);
    check("full_alu_e1", bus.wr_addr, 1);
    mem(1, 4'd7, 16'h7007);
    step();
    mem(1, 4'd8, 16'h8008);
    step();
    check("full_ready_e3", bus.mem_ready, 1);
    mem(1, 4'd9, 16'h9009);
    step();
    check("full_ready_e4", bus.mem_ready, 0);
    check("full_stall_e4", bus.alu_stall, 0);
    mem(1, 4'd10, 16'hA00A);
    step();
    check("full_ready_e5", bus.mem_ready, 0);
    check("full_stall_e5", bus.alu_stall, 1);
    check("full_alu_e5", bus.wr_addr, 1);
    step();
    check("full_pop_addr", bus.wr_addr, 6);
    check("full_pop_data", bus.wr_data, 16'h6006);
    check("full_stall_e6", bus.alu_stall, 0);
    check("full_ready_e6", bus.mem_ready, 1);
    step();
    mem(0, 0, 0);
    alu(0, 0, 0);
    check("full_alu_e7", bus.wr_addr, 1);
    check("full_ready_e7", bus.mem_ready, 0);
    step();
    check("drain7", bus.wr_data, 16'h7007);
    step();
    check("drain8", bus.wr_data, 16'h8008);
    step();
    check("drain9", bus.wr_data, 16'h9009);
    step();
    check("drain10_addr", bus.wr_addr, 10);
    check("drain10_data", bus.wr_data, 16'hA00A);
    step();
    check("drain_empty", bus.wr_en, 0);

    // Starvation: one buffered load and the ALU requesting every cycle
    alu(1, 4'd2, 16'h2222);
    mem(1, 4'd12, 16'hC00C);
    step();
    mem(0, 0, 0);
    check("st_alu_e1", bus.wr_addr, 2);
    step();
    check("st_stall_e2", bus.alu_stall, 0);
    step();
    step();
    check("st_stall_e4", bus.alu_stall, 0);
    step();
    check("st_stall_e5", bus.alu_stall, 1);
    check("st_alu_e5", bus.wr_addr, 2);
    step();
    check("st_load_addr", bus.wr_addr, 12);
    check("st_load_data", bus.wr_data, 16'hC00C);
    check("st_stall_e6", bus.alu_stall, 0);
    step();
    check("st_alu_resume", bus.wr_addr, 2);
    check("st_stall_e7", bus.alu_stall, 0);

    // Reset mid-run with three buffered loads: they are dropped
    alu(1, 4'd4, 16'h4444);
    mem(1, 4'd13, 16'hD00D);
    issue(1, 4'd9);
    step();
    issue(0, 0);
    mem(1, 4'd14, 16'hE00E);
    step();
    mem(1, 4'd15, 16'hF00F);
    step();
    check("mr_busy_pre", bus.busy_mask, 16'h0220);
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_wr_en", bus.wr_en, 0);
    check("mr_busy", bus.busy_mask, 0);
    check("mr_mem_ready", bus.mem_ready, 1);
    check("mr_stall", bus.alu_stall, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("mr_no_write_%0d", i), bus.wr_en, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
